// File: rtl/fmul_fma_r4.sv
// rtl/fmul_fma_r4.sv - two-stage binary32 multiply front end feeding the FMA adder
package fmul_fma_r4_pkg;
    typedef struct packed {
        logic [3:0] fu_op;
        logic [4:0] rd;
        logic       reg_write;
        logic       FP_reg_write;
    } exe_p_mux_bus_type;
endpackage

module fmul_fma_r4 import fmul_fma_r4_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        clear,
    input  logic [31:0]       num_a,
    input  logic [31:0]       num_b,
    input  logic              negate_product,
    input  logic              p_start,
    output logic              p_result,
    input  exe_p_mux_bus_type fmul_pipeline_signals_i,
    output exe_p_mux_bus_type fmul_pipeline_signals_o,
    output logic [7:0]        prod_exp,
    output logic [46:0]       prod_mant,
    output logic              prod_sign,
    output logic              prod_is_NaN,
    output logic              prod_is_inf,
    output logic              prod_is_zero,
    output logic [4:0]        uu_rd [0:1],
    output logic [1:0]        uu_reg_write,
    output logic [1:0]        uu_FP_reg_write
);
    // Operand unpack; exponent zero means zero (subnormals flushed)
    logic [23:0]       sig_a, sig_b;
    logic              a_nan_c, a_inf_c, a_zero_c, b_nan_c, b_inf_c, b_zero_c;
    logic signed [9:0] exp_sum_c;

    assign sig_a    = {num_a[30:23] != 8'd0, num_a[22:0]};
    assign sig_b    = {num_b[30:23] != 8'd0, num_b[22:0]};
    assign a_nan_c  = (num_a[30:23] == 8'hFF) && (num_a[22:0] != 23'd0);
    assign a_inf_c  = (num_a[30:23] == 8'hFF) && (num_a[22:0] == 23'd0);
    assign a_zero_c = (num_a[30:23] == 8'd0);
    assign b_nan_c  = (num_b[30:23] == 8'hFF) && (num_b[22:0] != 23'd0);
    assign b_inf_c  = (num_b[30:23] == 8'hFF) && (num_b[22:0] == 23'd0);
    assign b_zero_c = (num_b[30:23] == 8'd0);
    assign exp_sum_c = $signed({2'b00, num_a[30:23]}) + $signed({2'b00, num_b[30:23]}) - 10'sd127;

    // Stage 0 state: split partial products keep each multiplier at 24x12
    logic [35:0]       s0_pl, s0_ph;
    logic signed [9:0] s0_exp;
    logic              s0_sign, s0_valid;
    logic              s0_a_nan, s0_a_inf, s0_a_zero, s0_b_nan, s0_b_inf, s0_b_zero;
    exe_p_mux_bus_type s0_sb;

    // Stage 0 register: clear beats enable, enable beats hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || clear[0]) begin
            s0_pl <= '0; s0_ph <= '0; s0_exp <= '0; s0_sign <= 1'b0; s0_valid <= 1'b0;
            s0_a_nan <= 1'b0; s0_a_inf <= 1'b0; s0_a_zero <= 1'b0;
            s0_b_nan <= 1'b0; s0_b_inf <= 1'b0; s0_b_zero <= 1'b0;
            s0_sb <= '0;
        end else if (en) begin
            s0_pl     <= sig_a * sig_b[11:0];
            s0_ph     <= sig_a * sig_b[23:12];
            s0_exp    <= exp_sum_c;
            s0_sign   <= num_a[31] ^ num_b[31] ^ negate_product;
            s0_valid  <= p_start;
            s0_a_nan  <= a_nan_c;  s0_a_inf <= a_inf_c;  s0_a_zero <= a_zero_c;
            s0_b_nan  <= b_nan_c;  s0_b_inf <= b_inf_c;  s0_b_zero <= b_zero_c;
            s0_sb     <= fmul_pipeline_signals_i;
        end
    end

    // Stage 1 combine, normalize and classify
    logic [47:0]       prod_c;
    logic signed [9:0] e_c;
    logic [46:0]       mant_c, mant_n;
    logic [7:0]        exp_n;
    logic              sign_n, nan_n, inf_n, zero_n;

    assign prod_c = {12'd0, s0_pl} + {s0_ph, 12'd0};
    assign mant_c = prod_c[47] ? {prod_c[47:2], prod_c[1] | prod_c[0]} : prod_c[46:0];
    assign e_c    = s0_exp + (prod_c[47] ? 10'sd1 : 10'sd0);

    // Priority classification: NaN, then infinity, then zero, else normal
    always_comb begin
        exp_n  = e_c[7:0];
        mant_n = mant_c;
        sign_n = s0_sign;
        nan_n  = 1'b0;
        inf_n  = 1'b0;
        zero_n = 1'b0;
        if (s0_a_nan || s0_b_nan || (s0_a_inf && s0_b_zero) || (s0_a_zero && s0_b_inf)) begin
            nan_n = 1'b1; exp_n = 8'hFF; mant_n = 47'h200000000000; sign_n = 1'b0;
        end else if (s0_a_inf || s0_b_inf || (e_c >= 10'sd255)) begin
            inf_n = 1'b1; exp_n = 8'hFF; mant_n = '0;
        end else if (s0_a_zero || s0_b_zero || (e_c <= 10'sd0)) begin
            zero_n = 1'b1; exp_n = 8'h00; mant_n = '0;
        end
    end

    // Output register: same clear/enable/hold precedence as stage 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || clear[1]) begin
            prod_exp <= '0; prod_mant <= '0; prod_sign <= 1'b0;
            prod_is_NaN <= 1'b0; prod_is_inf <= 1'b0; prod_is_zero <= 1'b0;
            p_result <= 1'b0; fmul_pipeline_signals_o <= '0;
        end else if (en) begin
            prod_exp <= exp_n; prod_mant <= mant_n; prod_sign <= sign_n;
            prod_is_NaN <= nan_n; prod_is_inf <= inf_n; prod_is_zero <= zero_n;
            p_result <= s0_valid; fmul_pipeline_signals_o <= s0_sb;
        end
    end

    assign uu_rd[0]        = s0_sb.rd;
    assign uu_rd[1]        = fmul_pipeline_signals_o.rd;
    assign uu_reg_write    = {fmul_pipeline_signals_o.reg_write, s0_sb.reg_write};
    assign uu_FP_reg_write = {fmul_pipeline_signals_o.FP_reg_write, s0_sb.FP_reg_write};
endmodule

// File: tb/tb_fmul_fma_r4.sv
// tb/tb_fmul_fma_r4.sv - directed bench for fmul_fma_r4
module tb_fmul_fma_r4;
    import fmul_fma_r4_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [1:0]        clear;
    logic [31:0]       num_a, num_b;
    logic              negate_product, p_start, p_result;
    exe_p_mux_bus_type sb_i, sb_o;
    logic [7:0]        prod_exp;
    logic [46:0]       prod_mant;
    logic              prod_sign, prod_is_NaN, prod_is_inf, prod_is_zero;
    logic [4:0]        uu_rd [0:1];
    logic [1:0]        uu_reg_write, uu_FP_reg_write;

    int checks = 0;
    int errors = 0;

    fmul_fma_r4 dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .num_a(num_a), .num_b(num_b), .negate_product(negate_product),
        .p_start(p_start), .p_result(p_result),
        .fmul_pipeline_signals_i(sb_i), .fmul_pipeline_signals_o(sb_o),
        .prod_exp(prod_exp), .prod_mant(prod_mant), .prod_sign(prod_sign),
        .prod_is_NaN(prod_is_NaN), .prod_is_inf(prod_is_inf), .prod_is_zero(prod_is_zero),
        .uu_rd(uu_rd), .uu_reg_write(uu_reg_write), .uu_FP_reg_write(uu_FP_reg_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic neg,
                         input logic start, input logic [4:0] rd);
        num_a = a; num_b = b; negate_product = neg; p_start = start;
        sb_i = '0;
        sb_i.rd = rd;
        sb_i.reg_write = start;
        sb_i.FP_reg_write = start;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic neg);
        drive(a, b, neg, 1'b1, 5'd1);
        step();
        drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        step();
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e, input logic [46:0] m,
                           input logic s, input logic [2:0] flags);
        chk({tag, ".p_result"}, {63'd0, p_result}, 64'd1);
        chk({tag, ".exp"}, {56'd0, prod_exp}, {56'd0, e});
        chk({tag, ".mant"}, {17'd0, prod_mant}, {17'd0, m});
        chk({tag, ".sign"}, {63'd0, prod_sign}, {63'd0, s});
        chk({tag, ".flags"}, {61'd0, prod_is_NaN, prod_is_inf, prod_is_zero}, {61'd0, flags});
    endtask

    logic [7:0]  hold_exp;
    logic [46:0] hold_mant;

    initial begin
        rst = 1'b0; en = 1'b1; clear = 2'b00;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        step(); step();
        chk("reset.p_result", {63'd0, p_result}, 64'd0);
        chk("reset.exp", {56'd0, prod_exp}, 64'd0);
        chk("reset.sb", {54'd0, sb_o}, 64'd0);
        @(negedge clk); rst = 1'b1;

        run_op(32'h3FC00000, 32'h40000000, 1'b0);
        chk_out("1p5x2", 8'h80, 47'h600000000000, 1'b0, 3'b000);
        run_op(32'h3FC00000, 32'h3FC00000, 1'b0);
        chk_out("1p5sq", 8'h80, 47'h480000000000, 1'b0, 3'b000);
        run_op(32'h3FC00000, 32'h3FC00000, 1'b1);
        chk_out("1p5sq_neg", 8'h80, 47'h480000000000, 1'b1, 3'b000);
        run_op(32'h7F800000, 32'h00000000, 1'b0);
        chk_out("inf_x_0", 8'hFF, 47'h200000000000, 1'b0, 3'b100);
        run_op(32'h7F000000, 32'h7F000000, 1'b0);
        chk_out("ovf", 8'hFF, 47'h0, 1'b0, 3'b010);
        run_op(32'h00800000, 32'h00800000, 1'b0);
        chk_out("unf", 8'h00, 47'h0, 1'b0, 3'b001);
        run_op(32'h00000001, 32'h3F800000, 1'b0);
        chk_out("subn", 8'h00, 47'h0, 1'b0, 3'b001);
        run_op(32'hBF800000, 32'h40000000, 1'b0);
        chk_out("neg1x2", 8'h80, 47'h400000000000, 1'b1, 3'b000);

        // Back-to-back A (rd=3), B (rd=5) with B flushed out of stage 0
        drive(32'h3FC00000, 32'h40000000, 1'b0, 1'b1, 5'd3);
        step();
        chk("A.uu_rd0", {59'd0, uu_rd[0]}, 64'd3);
        drive(32'h40000000, 32'h40000000, 1'b0, 1'b1, 5'd5);
        clear = 2'b01;
        step();
        clear = 2'b00;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
        chk("A.p_result", {63'd0, p_result}, 64'd1);
        chk("A.uu_rd1", {59'd0, uu_rd[1]}, 64'd3);
        chk("A.exp", {56'd0, prod_exp}, 64'h80);
        chk("A.s0_flushed", {59'd0, uu_rd[0]}, 64'd0);
        step();
        chk("B.p_result", {63'd0, p_result}, 64'd0);
        chk("B.sb", {54'd0, sb_o}, 64'd0);
        chk("B.uu_wr", {60'd0, uu_reg_write, uu_FP_reg_write}, 64'd0);

        // Freeze with a live result in the output stage
        run_op(32'h3FC00000, 32'h3FC00000, 1'b1);
        hold_exp = prod_exp; hold_mant = prod_mant;
        en = 1'b0;
        drive(32'h40000000, 32'h40000000, 1'b0, 1'b1, 5'd9);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold.p_result", {63'd0, p_result}, 64'd1);
            chk("hold.exp", {56'd0, prod_exp}, 64'h80);
            chk("hold.mant", {17'd0, prod_mant}, {17'd0, 47'h480000000000});
            chk("hold.sign", {63'd0, prod_sign}, 64'd1);
            chk("hold.uu_rd0", {59'd0, uu_rd[0]}, 64'd0);
        end
        en = 1'b1;
        drive(32'd0, 32'd0, 1'b0, 1'b0, 5'd0);

        // Asynchronous reset mid-operation
        drive(32'h3FC00000, 32'h40000000, 1'b0, 1'b1, 5'd7);
        step();
        drive(32'h40000000, 32'h40000000, 1'b0, 1'b1, 5'd8);
        step();
        chk("prerst.p_result", {63'd0, p_result}, 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst.p_result", {63'd0, p_result}, 64'd0);
        chk("rst.exp_mant", {9'd0, prod_exp, prod_mant}, 64'd0);
        chk("rst.uu", {50'd0, uu_rd[0], uu_rd[1], uu_reg_write, uu_FP_reg_write}, 64'd0);
        chk("rst.sb", {54'd0, sb_o}, 64'd0);
        @(negedge clk); @(negedge clk); rst = 1'b1;
        run_op(32'h40400000, 32'h40000000, 1'b0);
        chk_out("post_rst", 8'h81, 47'h600000000000, 1'b0, 3'b000);
        chk("post_rst.rd", {59'd0, uu_rd[1]}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
